// File: rtl/branch_pkg.sv
// Shared types and constants for the BTB-based branch predictor.
package branch_pkg;

    // Default geometry; branch_predictor parameters must match these widths.
    localparam int unsigned BTB_DATA_WIDTH = 32;
    localparam int unsigned BTB_INDEX_BITS = 4;
    localparam int unsigned BTB_TAG_BITS   = BTB_DATA_WIDTH - BTB_INDEX_BITS - 2;

    // 2-bit saturating direction counter; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } ctr_t;

    typedef struct packed {
        logic                      valid;
        logic [BTB_TAG_BITS-1:0]   tag;
        logic [BTB_DATA_WIDTH-1:0] target;
        ctr_t                      ctr;
    } btb_entry_t;

    localparam ctr_t CTR_RESET = WEAK_NT;
    localparam ctr_t CTR_ALLOC = WEAK_T;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
module sat_counter2
    import branch_pkg::*;
(
    input  ctr_t ctr_i,
    input  logic taken_i,
    output ctr_t ctr_o
);

    // Step towards taken/not-taken, sticking at the strong states.
    always_comb begin
        ctr_o = ctr_i;
        unique case (ctr_i)
            STRONG_NT: ctr_o = taken_i ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   ctr_o = taken_i ? WEAK_T   : STRONG_NT;
            WEAK_T:    ctr_o = taken_i ? STRONG_T : WEAK_NT;
            STRONG_T:  ctr_o = taken_i ? STRONG_T : WEAK_T;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: fetch-side lookup, execute-side
// training, misprediction detection and statistics counters.
module branch_predictor
    import branch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = BTB_DATA_WIDTH,
    parameter int unsigned INDEX_BITS = BTB_INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] pcF,
    output logic                  predTakenF,
    output logic [DATA_WIDTH-1:0] predTargetF,
    input  logic                  branchE,
    input  logic                  stallE,
    input  logic [DATA_WIDTH-1:0] pcE,
    input  logic [DATA_WIDTH-1:0] targetE,
    input  logic                  takenE,
    input  logic                  predTakenE,
    input  logic [DATA_WIDTH-1:0] predTargetE,
    output logic                  mispredictE,
    output logic [DATA_WIDTH-1:0] redirectPcE,
    output logic [31:0]           branchCount,
    output logic [31:0]           mispredCount
);

    localparam int unsigned TAG_BITS = DATA_WIDTH - INDEX_BITS - 2;
    localparam int unsigned ENTRIES  = 1 << INDEX_BITS;

    // Flop array so the whole table clears on the asynchronous reset.
    btb_entry_t btb_q [ENTRIES];

    logic [INDEX_BITS-1:0] idx_f, idx_e;
    logic [TAG_BITS-1:0]   tag_f, tag_e;
    btb_entry_t            ent_f, ent_e;
    logic                  hit_f, hit_e;
    logic                  upd;
    ctr_t                  ctr_next;
    logic [31:0]           branch_cnt_q, mispred_cnt_q;

    // Word-offset bits never take part in indexing or tagging.
    logic unused_offset;
    assign unused_offset = ^{pcF[1:0], pcE[1:0]};

    assign idx_f = pcF[INDEX_BITS+1:2];
    assign tag_f = pcF[DATA_WIDTH-1:INDEX_BITS+2];
    assign idx_e = pcE[INDEX_BITS+1:2];
    assign tag_e = pcE[DATA_WIDTH-1:INDEX_BITS+2];
    assign ent_f = btb_q[idx_f];
    assign ent_e = btb_q[idx_e];
    assign hit_f = ent_f.valid && (ent_f.tag == tag_f);
    assign hit_e = ent_e.valid && (ent_e.tag == tag_e);
    assign upd   = branchE && !stallE;

    sat_counter2 u_sat_counter2 (
        .ctr_i   (ent_e.ctr),
        .taken_i (takenE),
        .ctr_o   (ctr_next)
    );

    // Fetch lookup reads pre-update contents; held not-taken during reset.
    always_comb begin
        predTakenF  = rst_n && hit_f && ent_f.ctr[1];
        predTargetF = predTakenF ? ent_f.target : pcF + DATA_WIDTH'(4);
    end

    // Resolve the execute-stage branch; asserted regardless of stallE.
    always_comb begin
        mispredictE = branchE && ((takenE != predTakenE) ||
                      (takenE && predTakenE && (predTargetE != targetE)));
        redirectPcE = takenE ? targetE : pcE + DATA_WIDTH'(4);
    end

    // Train on hit, allocate on taken miss, leave table alone on not-taken miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i].valid  <= 1'b0;
                btb_q[i].tag    <= '0;
                btb_q[i].target <= '0;
                btb_q[i].ctr    <= CTR_RESET;
            end
        end else if (upd) begin
            if (hit_e) begin
                btb_q[idx_e].ctr <= ctr_next;
                if (takenE) begin
                    btb_q[idx_e].target <= targetE;
                end
            end else if (takenE) begin
                btb_q[idx_e].valid  <= 1'b1;
                btb_q[idx_e].tag    <= tag_e;
                btb_q[idx_e].target <= targetE;
                btb_q[idx_e].ctr    <= CTR_ALLOC;
            end
        end
    end

    // One count per retired branch update; both wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (upd) begin
            branch_cnt_q <= branch_cnt_q + 32'd1;
            if (mispredictE) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign branchCount  = branch_cnt_q;
    assign mispredCount = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences,
// then random traffic against a behavioural BTB model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pcF, pcE, targetE, predTargetE;
    logic        branchE, stallE, takenE, predTakenE;
    logic        predTakenF, mispredictE;
    logic [31:0] predTargetF, redirectPcE, branchCount, mispredCount;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pcF          (pcF),
        .predTakenF   (predTakenF),
        .predTargetF  (predTargetF),
        .branchE      (branchE),
        .stallE       (stallE),
        .pcE          (pcE),
        .targetE      (targetE),
        .takenE       (takenE),
        .predTakenE   (predTakenE),
        .predTargetE  (predTargetE),
        .mispredictE  (mispredictE),
        .redirectPcE  (redirectPcE),
        .branchCount  (branchCount),
        .mispredCount (mispredCount)
    );

    typedef struct {
        logic [31:0] pc_f;
        bit          br;
        bit          st;
        logic [31:0] pc_e;
        logic [31:0] tgt_e;
        bit          tk;
        bit          pt_e;
        logic [31:0] ptgt_e;
        bit          x_pt;
        logic [31:0] x_ptgt;
        bit          x_mis;
        logic [31:0] x_redir;
    } vec_t;

    vec_t vq[$];

    // Behavioural model: one record per BTB slot, counter as a plain integer.
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    int unsigned m_bc, m_mc;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] pf, input bit br, input bit st,
                         input logic [31:0] pe, input logic [31:0] te, input bit tk,
                         input bit pt, input logic [31:0] ptg);
        pcF = pf; branchE = br; stallE = st; pcE = pe; targetE = te;
        takenE = tk; predTakenE = pt; predTargetE = ptg;
    endtask

    task automatic idle(input logic [31:0] pf);
        drive(pf, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
        end
        m_bc = 0; m_mc = 0;
    endfunction

    function automatic void m_predict(input logic [31:0] pc, output bit t,
                                      output logic [31:0] tg);
        int i = int'(pc[5:2]);
        t  = m_valid[i] && (m_tag[i] == pc[31:6]) && (m_ctr[i] >= 2);
        tg = t ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic void m_train(input logic [31:0] pc, input logic [31:0] tg, input bit t);
        int i = int'(pc[5:2]);
        if (m_valid[i] && m_tag[i] == pc[31:6]) begin
            m_ctr[i] = t ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                         : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
            if (t) m_tgt[i] = tg;
        end else if (t) begin
            m_valid[i] = 1'b1; m_tag[i] = pc[31:6]; m_tgt[i] = tg; m_ctr[i] = 2;
        end
    endfunction

    initial begin
        logic [31:0] pool [8];
        logic [31:0] xptg, ptg;
        bit          xpt, xmis, pt;

        pool = '{32'h100, 32'h140, 32'h180, 32'h104, 32'h108, 32'h200, 32'h3C0, 32'h144};

        // pc_f br st pc_e tgt_e tk pt_e ptgt_e | x_pt x_ptgt x_mis x_redir
        vq.push_back('{32'h100, 0, 0, 32'h000, 32'h000, 0, 0, 32'h000, 0, 32'h104, 0, 32'h004});
        vq.push_back('{32'h100, 1, 0, 32'h100, 32'h080, 1, 0, 32'h000, 0, 32'h104, 1, 32'h080});
        vq.push_back('{32'h100, 0, 0, 32'h000, 32'h000, 0, 0, 32'h000, 1, 32'h080, 0, 32'h004});
        vq.push_back('{32'h100, 1, 0, 32'h100, 32'h080, 1, 1, 32'h080, 1, 32'h080, 0, 32'h080});
        vq.push_back('{32'h100, 1, 0, 32'h100, 32'h080, 0, 1, 32'h080, 1, 32'h080, 1, 32'h104});
        vq.push_back('{32'h100, 0, 0, 32'h000, 32'h000, 0, 0, 32'h000, 1, 32'h080, 0, 32'h004});
        vq.push_back('{32'h100, 1, 0, 32'h100, 32'h080, 0, 1, 32'h080, 1, 32'h080, 1, 32'h104});
        vq.push_back('{32'h100, 0, 0, 32'h000, 32'h000, 0, 0, 32'h000, 0, 32'h104, 0, 32'h004});
        vq.push_back('{32'h100, 1, 0, 32'h100, 32'h080, 1, 0, 32'h000, 0, 32'h104, 1, 32'h080});
        vq.push_back('{32'h100, 1, 0, 32'h100, 32'h200, 1, 1, 32'h080, 1, 32'h080, 1, 32'h200});
        vq.push_back('{32'h100, 0, 0, 32'h000, 32'h000, 0, 0, 32'h000, 1, 32'h200, 0, 32'h004});
        vq.push_back('{32'h100, 1, 0, 32'h140, 32'h300, 1, 0, 32'h000, 1, 32'h200, 1, 32'h300});
        vq.push_back('{32'h100, 0, 0, 32'h000, 32'h000, 0, 0, 32'h000, 0, 32'h104, 0, 32'h004});
        vq.push_back('{32'h140, 0, 0, 32'h000, 32'h000, 0, 0, 32'h000, 1, 32'h300, 0, 32'h004});
        vq.push_back('{32'h208, 1, 0, 32'h208, 32'h400, 0, 0, 32'h000, 0, 32'h20C, 0, 32'h20C});
        vq.push_back('{32'h208, 0, 0, 32'h000, 32'h000, 0, 0, 32'h000, 0, 32'h20C, 0, 32'h004});

        rst_n = 1'b0;
        idle(32'h100);
        #1;
        chk("reset_predTakenF", {31'b0, predTakenF}, 32'h0);
        chk("reset_predTargetF", predTargetF, 32'h104);
        chk("reset_branchCount", branchCount, 32'h0);
        chk("reset_mispredCount", mispredCount, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table: one vector per cycle, update on the next edge.
        foreach (vq[k]) begin
            @(negedge clk);
            drive(vq[k].pc_f, vq[k].br, vq[k].st, vq[k].pc_e, vq[k].tgt_e,
                  vq[k].tk, vq[k].pt_e, vq[k].ptgt_e);
            #1;
            chk($sformatf("vec%0d_predTakenF", k), {31'b0, predTakenF}, {31'b0, vq[k].x_pt});
            chk($sformatf("vec%0d_predTargetF", k), predTargetF, vq[k].x_ptgt);
            chk($sformatf("vec%0d_mispredictE", k), {31'b0, mispredictE}, {31'b0, vq[k].x_mis});
            if (vq[k].br) chk($sformatf("vec%0d_redirectPcE", k), redirectPcE, vq[k].x_redir);
        end
        @(negedge clk);
        idle(32'h0);
        #1;
        chk("table_branchCount", branchCount, 32'd8);
        chk("table_mispredCount", mispredCount, 32'd6);

        // Counters from a clean state: 10 branches, 3 of them mispredicted.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(32'h0, 1'b1, 1'b0, 32'h400 + 32'(4 * i), 32'h800, (i == 2 || i == 5 || i == 7),
                  1'b0, 32'h0);
        end
        @(negedge clk);
        idle(32'h0);
        #1;
        chk("ten_branchCount", branchCount, 32'd10);
        chk("ten_mispredCount", mispredCount, 32'd3);

        // Stalled branch held 3 cycles: flagged each cycle, counted once.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(32'h100, 1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 1'b0, 32'h0);
            #1;
            chk($sformatf("stall%0d_mispredictE", i), {31'b0, mispredictE}, 32'h1);
            chk($sformatf("stall%0d_branchCount", i), branchCount, 32'd10);
            chk($sformatf("stall%0d_predTakenF", i), {31'b0, predTakenF}, 32'h0);
        end
        @(negedge clk);
        stallE = 1'b0;
        @(negedge clk);
        idle(32'h100);
        #1;
        chk("stall_branchCount", branchCount, 32'd11);
        chk("stall_mispredCount", mispredCount, 32'd4);
        chk("stall_predTakenF", {31'b0, predTakenF}, 32'h1);
        chk("stall_predTargetF", predTargetF, 32'h80);

        // Asynchronous reset mid-cycle clears the table immediately.
        #2 rst_n = 1'b0;
        #1;
        chk("async_predTakenF", {31'b0, predTakenF}, 32'h0);
        chk("async_predTargetF", predTargetF, 32'h104);
        chk("async_branchCount", branchCount, 32'h0);

        // Update presented while in reset is dropped.
        @(negedge clk);
        drive(32'h500, 1'b1, 1'b0, 32'h500, 32'h600, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(32'h500);
        #1;
        chk("rstupd_predTakenF", {31'b0, predTakenF}, 32'h0);
        chk("rstupd_branchCount", branchCount, 32'h0);

        // Random traffic against the model.
        m_reset();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            pcF     = pool[$urandom_range(0, 7)];
            pcE     = pool[$urandom_range(0, 7)];
            branchE = ($urandom_range(0, 3) != 0);
            stallE  = ($urandom_range(0, 3) == 0);
            takenE  = $urandom_range(0, 1);
            targetE = {$urandom_range(0, 7), 6'b0} + 32'h1000;
            m_predict(pcE, pt, ptg);
            if ($urandom_range(0, 3) != 0) begin
                predTakenE = pt; predTargetE = ptg;
            end else begin
                predTakenE = $urandom_range(0, 1);
                predTargetE = {$urandom_range(0, 7), 6'b0} + 32'h1000;
            end
            #1;
            m_predict(pcF, xpt, xptg);
            xmis = branchE && ((takenE != predTakenE) ||
                               (takenE && predTakenE && predTargetE != targetE));
            chk("rnd_predTakenF", {31'b0, predTakenF}, {31'b0, xpt});
            chk("rnd_predTargetF", predTargetF, xptg);
            chk("rnd_mispredictE", {31'b0, mispredictE}, {31'b0, xmis});
            if (branchE) chk("rnd_redirectPcE", redirectPcE, takenE ? targetE : pcE + 32'd4);
            chk("rnd_branchCount", branchCount, m_bc);
            chk("rnd_mispredCount", mispredCount, m_mc);
            @(posedge clk);
            if (branchE && !stallE) begin
                m_bc++;
                if (xmis) m_mc++;
                m_train(pcE, targetE, takenE);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
